// File: rtl/codifica_hamming.sv
// Streaming Hamming(15,11) encoder with optional single-bit error injection.
// Ports: clk/rst_n; dado_in, in_valid, in_ready, inj_en, inj_pos (input side);
//        palavra_out, out_valid, out_ready (output side); nivel, erros_injetados.
module codifica_hamming #(
  parameter int PROF      = 4,
  parameter int LARG_CONT = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [10:0]             dado_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    inj_en,
  input  logic [3:0]              inj_pos,
  output logic [14:0]             palavra_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(PROF):0]   nivel,
  output logic [LARG_CONT-1:0]    erros_injetados
);

  localparam int AW = $clog2(PROF);

  logic [14:0]   mem [PROF];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW-1:0] rptr_nxt;
  logic [14:0]   cw;
  logic [14:0]   cw_inj;
  logic [15:0]   mask;
  logic [14:0]   head_nxt;
  logic          flip;
  logic          push;
  logic          pop;

  function automatic logic [14:0] encode(input logic [10:0] d);
    logic [14:0] c;
    c     = '0;
    c[2]  = d[0];
    c[4]  = d[1];
    c[5]  = d[2];
    c[6]  = d[3];
    c[8]  = d[4];
    c[9]  = d[5];
    c[10] = d[6];
    c[11] = d[7];
    c[12] = d[8];
    c[13] = d[9];
    c[14] = d[10];
    c[0]  = c[2] ^ c[4] ^ c[6] ^ c[8] ^ c[10] ^ c[12] ^ c[14];
    c[1]  = c[2] ^ c[5] ^ c[6] ^ c[9] ^ c[10] ^ c[13] ^ c[14];
    c[3]  = c[4] ^ c[5] ^ c[6] ^ c[11] ^ c[12] ^ c[13] ^ c[14];
    c[7]  = c[8] ^ c[9] ^ c[10] ^ c[11] ^ c[12] ^ c[13] ^ c[14];
    return c;
  endfunction

  assign in_ready  = (nivel != (AW+1)'(PROF));
  assign out_valid = (nivel != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign rptr_nxt  = pop ? rptr + 1'b1 : rptr;

  // 1-based position: bit 0 of the shifted mask is the "no flip" slot
  always_comb begin
    cw     = encode(dado_in);
    mask   = 16'(1) << inj_pos;
    flip   = inj_en && (inj_pos != 4'd0);
    cw_inj = inj_en ? (cw ^ mask[15:1]) : cw;
  end

  // The new head is the incoming word only when it lands
  // in the slot the read pointer moves to (FIFO otherwise empty).
  always_comb begin
    if (push && (wptr == rptr_nxt)) begin
      head_nxt = cw_inj;
    end else begin
      head_nxt = mem[rptr_nxt];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PROF; i++) begin
        mem[i] <= '0;
      end
      wptr            <= '0;
      rptr            <= '0;
      nivel           <= '0;
      palavra_out     <= '0;
      erros_injetados <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= cw_inj;
        wptr      <= wptr + 1'b1;
      end
      rptr        <= rptr_nxt;
      palavra_out <= head_nxt;
      case ({push, pop})
        2'b10:   nivel <= nivel + 1'b1;
        2'b01:   nivel <= nivel - 1'b1;
        default: nivel <= nivel;
      endcase
      if (push && flip && (erros_injetados != '1)) begin
        erros_injetados <= erros_injetados + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_codifica_hamming.sv
// Self-checking bench for codifica_hamming: randomized traffic against a
// position-based Hamming model and a queue scoreboard.
module tb_codifica_hamming;

  localparam int PROF = 4;
  localparam int LC   = 3;
  localparam int CMAX = (1 << LC) - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] dado_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        inj_en = 1'b0;
  logic [3:0]  inj_pos = '0;
  logic [14:0] palavra_out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  nivel;
  logic [LC-1:0] erros_injetados;

  always #5 clk = ~clk;

  codifica_hamming #(.PROF(PROF), .LARG_CONT(LC)) dut (
    .clk(clk), .rst_n(rst_n), .dado_in(dado_in), .in_valid(in_valid),
    .in_ready(in_ready), .inj_en(inj_en), .inj_pos(inj_pos),
    .palavra_out(palavra_out), .out_valid(out_valid),
    .out_ready(out_ready), .nivel(nivel),
    .erros_injetados(erros_injetados)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", n, a, e);
    end
  endtask

  // Data fills non-power-of-two positions 1..15; parity at 2^b covers
  // every position whose index has bit b set.
  function automatic logic [14:0] model_enc(input logic [10:0] d);
    logic [15:1] p;
    int k;
    p = '0;
    k = 0;
    for (int pos = 1; pos <= 15; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        p[pos] = d[k];
        k++;
      end
    end
    for (int b = 0; b < 4; b++) begin
      logic x;
      x = 1'b0;
      for (int pos = 1; pos <= 15; pos++)
        if (((pos >> b) & 1) == 1) x ^= p[pos];
      p[1 << b] = x;
    end
    return p;
  endfunction

  function automatic logic [10:0] model_dec(input logic [14:0] c);
    logic [15:1] p;
    int syn;
    int k;
    logic [10:0] d;
    p = c;
    syn = 0;
    for (int pos = 1; pos <= 15; pos++)
      if (p[pos]) syn ^= pos;
    if (syn != 0) p[syn] = ~p[syn];
    k = 0;
    d = '0;
    for (int pos = 1; pos <= 15; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[k] = p[pos];
        k++;
      end
    end
    return d;
  endfunction

  logic [14:0] q[$];
  logic [10:0] dq[$];
  int merr = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      dq.delete();
      merr = 0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_nivel", nivel, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_palavra", palavra_out, 0);
      chk("rst_erros", erros_injetados, 0);
    end else begin
      int sz;
      logic [14:0] w;
      logic fl;
      sz = q.size();
      chk("out_valid", out_valid, sz != 0);
      chk("nivel", nivel, sz);
      chk("in_ready", in_ready, sz != PROF);
      chk("erros", erros_injetados, merr);
      if (sz != 0) chk("palavra", palavra_out, q[0]);
      w = model_enc(dado_in);
      fl = inj_en && (inj_pos != 0);
      if (fl) w[inj_pos - 1] = ~w[inj_pos - 1];
      if (sz != 0 && out_ready) begin
        chk("corrige", model_dec(q[0]), dq[0]);
        void'(q.pop_front());
        void'(dq.pop_front());
      end
      if (in_valid && sz < PROF) begin
        q.push_back(w);
        dq.push_back(dado_in);
        if (fl && merr < CMAX) merr++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    inj_en = 1'b0;
    inj_pos = '0;
  endtask

  initial begin
    chk("m_000", model_enc(11'h000), 15'h0000);
    chk("m_001", model_enc(11'h001), 15'h0007);
    chk("m_7ff", model_enc(11'h7FF), 15'h7FFF);

    step(); step();
    rst_n = 1'b1;

    // first word latency
    dado_in = 11'h000; in_valid = 1'b1;
    step();
    idle();
    chk("t1_valid", out_valid, 1);
    chk("t1_pal", palavra_out, 15'h0000);
    chk("t1_nivel", nivel, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    dado_in = 11'h001; in_valid = 1'b1;
    step();
    dado_in = 11'h7FF;
    step();
    idle();
    chk("t2_pal", palavra_out, 15'h0007);
    out_ready = 1'b1;
    step();
    chk("t2_pal2", palavra_out, 15'h7FFF);
    chk("t2_err", erros_injetados, 0);
    step();
    out_ready = 1'b0;

    dado_in = 11'h000; in_valid = 1'b1; inj_en = 1'b1; inj_pos = 4'd5;
    step();
    inj_pos = 4'd0;
    step();
    idle();
    chk("t3_pal", palavra_out, 15'h0010);
    chk("t3_err", erros_injetados, 1);
    out_ready = 1'b1;
    step();
    chk("t3_pal0", palavra_out, 15'h0000);
    chk("t3_err0", erros_injetados, 1);
    step();
    out_ready = 1'b0;

    // fill, refuse fifth
    for (int i = 0; i < PROF + 2; i++) begin
      dado_in = 11'($urandom); in_valid = 1'b1;
      step();
    end
    chk("full_ready", in_ready, 0);
    chk("full_nivel", nivel, PROF);
    idle();
    out_ready = 1'b1;
    repeat (PROF) step();
    chk("drain_nivel", nivel, 0);

    // streaming
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      dado_in = 11'($urandom);
      inj_en = 1'($urandom);
      inj_pos = 4'($urandom);
      step();
      chk("stream_nivel", nivel, 1);
    end
    idle();
    step();

    // random traffic, drives counter into saturation
    for (int i = 0; i < 400; i++) begin
      dado_in = 11'($urandom);
      in_valid = 1'($urandom);
      inj_en = ($urandom_range(3) == 0);
      inj_pos = 4'($urandom);
      out_ready = 1'($urandom);
      step();
    end
    chk("sat_err", erros_injetados, CMAX);
    idle();
    out_ready = 1'b1;
    repeat (PROF + 1) step();

    // async reset with stored words
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dado_in = 11'($urandom); in_valid = 1'b1; inj_en = 1'b1;
      inj_pos = 4'd1;
      step();
    end
    idle();
    chk("pre_rst_nivel", nivel, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_nivel", nivel, 0);
    chk("arst_err", erros_injetados, 0);
    chk("arst_pal", palavra_out, 0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    rst_n = 1'b1;
    dado_in = 11'h123; in_valid = 1'b1;
    step();
    idle();
    chk("post_rst_pal", palavra_out, model_enc(11'h123));
    chk("post_rst_nivel", nivel, 1);
    out_ready = 1'b1;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
